// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pkg
// Purpose  : Shared FSM encodings and mode constants for the counter control
//            front-end.
// Revision : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED   = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_PRESSED    = 2'd2,
        ST_RELEASE_DB = 2'd3
    } db_state_e;

    localparam logic MODE_UP = 1'b1;
    localparam logic MODE_DN = 1'b0;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Purpose  : Two-flop synchronizer, debounce counter and press/release FSM;
//            emits the debounced level and a one-cycle press pulse.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce
    import ctrl_pkg::*;
#(
    parameter int DB_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic btn_db,
    output logic press
);

    localparam int            DW      = $clog2(DB_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          btn_db_q, btn_db_d;
    db_state_e     state_q, state_d;
    logic          db_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            cnt_q    <= '0;
            btn_db_q <= 1'b0;
            state_q  <= ST_RELEASED;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            cnt_q    <= cnt_d;
            btn_db_q <= btn_db_d;
            state_q  <= state_d;
        end
    end

    always_comb begin
        s1_d     = btn;
        s2_d     = s1_q;
        cnt_d    = '0;
        btn_db_d = btn_db_q;
        db_done  = (s2_q != btn_db_q) && (cnt_q == DB_LAST);
        if (s2_q != btn_db_q) begin
            if (db_done) begin
                btn_db_d = s2_q;
            end else begin
                cnt_d = cnt_q + DW'(1);
            end
        end
    end

    // With DB_CYCLES == 1 debounce can finish while still in a settled state,
    // so the settled states may jump straight across.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RELEASED: begin
                if (s2_q) state_d = db_done ? ST_PRESSED : ST_PRESS_DB;
            end
            ST_PRESS_DB: begin
                if (db_done)    state_d = ST_PRESSED;
                else if (!s2_q) state_d = ST_RELEASED;
            end
            ST_PRESSED: begin
                if (!s2_q) state_d = db_done ? ST_RELEASED : ST_RELEASE_DB;
            end
            ST_RELEASE_DB: begin
                if (db_done)   state_d = ST_RELEASED;
                else if (s2_q) state_d = ST_PRESSED;
            end
            default: state_d = ST_RELEASED;
        endcase
    end

    assign press  = ((state_q == ST_RELEASED) || (state_q == ST_PRESS_DB)) &&
                    (state_d == ST_PRESSED);
    assign btn_db = btn_db_q;

endmodule
`default_nettype wire

// File: rtl/counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : counter_ctrl
// Purpose  : Tick prescaler and debounced direction toggle driving a mod-N
//            up/down counter.
// Revision : 1.0 - initial release
// ============================================================================
module counter_ctrl
    import ctrl_pkg::*;
#(
    parameter int   TICK_DIV   = 50,
    parameter int   DB_CYCLES  = 8,
    parameter logic MODE_RESET = MODE_UP
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic btn,
    output logic tick,
    output logic mode,
    output logic mode_chg,
    output logic btn_db
);

    localparam int            PW      = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] ps_q, ps_d;
    logic          tick_q, tick_d;
    logic          mode_q, mode_d;
    logic          mode_chg_q, mode_chg_d;
    logic          press;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_btn_debounce (
        .clk    (clk),
        .reset  (reset),
        .btn    (btn),
        .btn_db (btn_db),
        .press  (press)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ps_q       <= '0;
            tick_q     <= 1'b0;
            mode_q     <= MODE_RESET;
            mode_chg_q <= 1'b0;
        end else begin
            ps_q       <= ps_d;
            tick_q     <= tick_d;
            mode_q     <= mode_d;
            mode_chg_q <= mode_chg_d;
        end
    end

    // A toggle restarts the tick period and swallows a coincident tick, so
    // the first tick in the new direction is a full period away.
    always_comb begin
        ps_d       = ps_q;
        tick_d     = 1'b0;
        mode_d     = mode_q;
        mode_chg_d = press;
        if (press) begin
            ps_d   = '0;
            mode_d = (mode_q == MODE_UP) ? MODE_DN : MODE_UP;
        end else if (en) begin
            if (ps_q == PS_LAST) begin
                ps_d   = '0;
                tick_d = 1'b1;
            end else begin
                ps_d = ps_q + PW'(1);
            end
        end
    end

    assign tick     = tick_q;
    assign mode     = mode_q;
    assign mode_chg = mode_chg_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_ctrl
// Purpose  : Scoreboard bench for counter_ctrl (TICK_DIV=4, DB_CYCLES=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_ctrl;

    localparam int SIG_TICK = 0;
    localparam int SIG_MODE = 1;
    localparam int SIG_CHG  = 2;
    localparam int SIG_DB   = 3;

    typedef struct {
        string name;
        bit    is_tick;
        int    cyc;
        bit    mode;
    } ev_t;

    typedef struct {
        string name;
        int    sig;
        int    cyc;
        bit    val;
    } probe_t;

    logic clk;
    logic reset;
    logic en;
    logic btn;
    logic tick;
    logic mode;
    logic mode_chg;
    logic btn_db;

    int   cyc = -3;
    bit   done = 1'b0;
    int   checks = 0;
    int   errors = 0;
    ev_t    ev_q[$];
    probe_t pr_q[$];
    ev_t    e;
    probe_t p;
    logic   act;

    counter_ctrl #(
        .TICK_DIV   (4),
        .DB_CYCLES  (8),
        .MODE_RESET (1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .btn      (btn),
        .tick     (tick),
        .mode     (mode),
        .mode_chg (mode_chg),
        .btn_db   (btn_db)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic at_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_ev(input string name, input bit is_tick, input int c, input bit m);
        ev_t t;
        t.name = name; t.is_tick = is_tick; t.cyc = c; t.mode = m;
        ev_q.push_back(t);
    endtask

    task automatic exp_probe(input string name, input int sig, input int c, input bit v);
        probe_t t;
        t.name = name; t.sig = sig; t.cyc = c; t.val = v;
        pr_q.push_back(t);
    endtask

    // Monitor: pops the event queue on every tick/mode_chg pulse and the
    // probe queue when its cycle comes up.
    always @(negedge clk) begin
        if (tick || mode_chg) begin
            if (tick && mode_chg) begin
                checks++;
                errors++;
                $display("FAIL collision cyc=%0d tick=1 mode_chg=1 required not both high", cyc);
            end
            checks++;
            if (ev_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d tick=%0b mode_chg=%0b required no pulse",
                         cyc, tick, mode_chg);
            end else begin
                e = ev_q.pop_front();
                if ((e.is_tick != tick) || (e.cyc != cyc) || (!e.is_tick && (mode != e.mode))) begin
                    errors++;
                    $display("FAIL %s actual cyc=%0d tick=%0b mode=%0b required cyc=%0d tick=%0b mode=%0b",
                             e.name, cyc, tick, mode, e.cyc, e.is_tick, e.mode);
                end
            end
        end
        while ((pr_q.size() > 0) && (pr_q[0].cyc <= cyc)) begin
            p = pr_q.pop_front();
            case (p.sig)
                SIG_TICK: act = tick;
                SIG_MODE: act = mode;
                SIG_CHG:  act = mode_chg;
                default:  act = btn_db;
            endcase
            checks++;
            if (act !== p.val) begin
                errors++;
                $display("FAIL %s cyc=%0d actual=%0b required=%0b", p.name, cyc, act, p.val);
            end
        end
        if (done) begin
            checks++;
            if ((ev_q.size() != 0) || (pr_q.size() != 0)) begin
                errors++;
                $display("FAIL missing_events actual_pending=%0d required_pending=0",
                         ev_q.size() + pr_q.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        reset = 1'b1;
        en    = 1'b1;
        btn   = 1'b0;
        exp_probe("rst_tick",     SIG_TICK, -1, 1'b0);
        exp_probe("rst_mode",     SIG_MODE, -1, 1'b1);
        exp_probe("rst_mode_chg", SIG_CHG,  -1, 1'b0);
        exp_probe("rst_btn_db",   SIG_DB,   -1, 1'b0);

        // Tick period, then 3-cycle enable gap delays the fourth tick by 3
        exp_ev("tick_4",  1'b1, 4,  1'b0);
        exp_ev("tick_8",  1'b1, 8,  1'b0);
        exp_ev("tick_12", 1'b1, 12, 1'b0);
        exp_ev("tick_19", 1'b1, 19, 1'b0);
        exp_ev("tick_23", 1'b1, 23, 1'b0);
        at_cycle(0);  reset = 1'b0;
        at_cycle(14); en = 1'b0;
        at_cycle(17); en = 1'b1;
        at_cycle(23); en = 1'b0;

        // Clean press sampled at edge 30, held 40 cycles
        exp_ev("press_chg_39", 1'b0, 39, 1'b0);
        exp_probe("held_btn_db", SIG_DB,   50, 1'b1);
        exp_probe("held_mode",   SIG_MODE, 50, 1'b0);
        exp_probe("rel_btn_db",  SIG_DB,   85, 1'b0);
        at_cycle(29); btn = 1'b1;
        at_cycle(69); btn = 1'b0;

        // Bounce 5 high / 2 low / 5 high, then a stable press
        exp_probe("bounce_mode",   SIG_MODE, 100, 1'b0);
        exp_probe("bounce_btn_db", SIG_DB,   100, 1'b0);
        exp_ev("stable_chg_120", 1'b0, 120, 1'b1);
        exp_probe("stable_mode", SIG_MODE, 130, 1'b1);
        at_cycle(89);  btn = 1'b1;
        at_cycle(94);  btn = 1'b0;
        at_cycle(96);  btn = 1'b1;
        at_cycle(101); btn = 1'b0;
        at_cycle(110); btn = 1'b1;
        at_cycle(125); btn = 1'b0;

        // Toggle lands on the terminal count at edge 148
        exp_ev("tick_144", 1'b1, 144, 1'b0);
        exp_ev("coll_chg_148", 1'b0, 148, 1'b0);
        exp_probe("coll_tick", SIG_TICK, 150, 1'b0);
        exp_probe("coll_mode", SIG_MODE, 150, 1'b0);
        exp_ev("tick_152", 1'b1, 152, 1'b0);
        at_cycle(138); btn = 1'b1;
        at_cycle(140); en  = 1'b1;
        at_cycle(152); en  = 1'b0;
        at_cycle(160); btn = 1'b0;

        // Reset during PRESS_DB with the button held
        exp_probe("midrst_mode",     SIG_MODE, 181, 1'b1);
        exp_probe("midrst_mode_chg", SIG_CHG,  181, 1'b0);
        exp_probe("midrst_btn_db",   SIG_DB,   181, 1'b0);
        exp_ev("postrst_chg_191", 1'b0, 191, 1'b0);
        exp_probe("postrst_mode",   SIG_MODE, 200, 1'b0);
        exp_probe("postrst_btn_db", SIG_DB,   200, 1'b1);
        at_cycle(175); btn   = 1'b1;
        at_cycle(180); reset = 1'b1;
        at_cycle(181); reset = 1'b0;
        at_cycle(195); btn   = 1'b0;
        at_cycle(215); done  = 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL timeout cyc=%0d required finish by cycle 215", cyc);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
